// File: rtl/counter_pkg.sv
// Shared definitions for the frequency meter: FSM states,
// BCD digit width and gate window length.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    function automatic int gate_cycles(input int clk_hz, input int gate_hz);
        return clk_hz / gate_hz;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the edge counter; wraps 9 -> 0 and
// raises carry for the next digit in the chain.
module bcd_digit
    import counter_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic at_nine;

    assign at_nine = (digit == DIGIT_W'(9));
    assign carry   = inc & at_nine;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= at_nine ? '0 : digit + 1'b1;
        end
    end

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of SIG over a gate window timed from CLK
// and presents the count as BCD, re-measuring while EN is high.
module frequency_meter
    import counter_pkg::*;
#(
    parameter int ClockFrequency = 1000000,
    parameter int GateFrequency  = 1,
    parameter int Digits         = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      SIG,
    output logic [DIGIT_W*Digits-1:0] BCD,
    output logic                      Overflow,
    output logic                      Valid
);

    localparam int GATE_CYCLES = gate_cycles(ClockFrequency, GateFrequency);
    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

    state_t state, next_state;

    logic s1, s2, s3;
    logic sig_edge;
    logic [TW-1:0] timer;
    logic sticky;
    logic [DIGIT_W*Digits-1:0] count;
    logic [Digits:0] carry;
    logic [Digits-1:0] nine;
    logic sat, gate_edge, cnt_inc, clr;
    logic carry_unused;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= SIG;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping EN aborts the window even on its last cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (EN) next_state = GATE;
            end
            GATE: begin
                if (!EN) next_state = IDLE;
                else if (timer == LAST) next_state = LATCH;
            end
            LATCH: begin
                next_state = EN ? GATE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer <= '0;
        end else if (state == GATE && next_state == GATE) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    assign gate_edge = (state == GATE) & sig_edge;
    assign sat       = &nine;
    assign cnt_inc   = gate_edge & ~sat;
    assign clr       = (state != GATE);
    assign carry[0]  = cnt_inc;
    assign carry_unused = carry[Digits];

    genvar gi;
    generate
        for (gi = 0; gi < Digits; gi++) begin : g_digit
            bcd_digit u_digit (
                .CLK   (CLK),
                .RST   (RST),
                .clr   (clr),
                .inc   (carry[gi]),
                .digit (count[gi*DIGIT_W +: DIGIT_W]),
                .carry (carry[gi+1])
            );
            assign nine[gi] = (count[gi*DIGIT_W +: DIGIT_W] == DIGIT_W'(9));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST || state != GATE) begin
            sticky <= 1'b0;
        end else if (gate_edge && sat) begin
            sticky <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            BCD      <= '0;
            Overflow <= 1'b0;
            Valid    <= 1'b0;
        end else begin
            Valid <= (state == LATCH);
            if (state == LATCH) begin
                BCD      <= count;
                Overflow <= sticky;
            end
        end
    end

endmodule
